// File: rtl/mem_pkg.sv
// Shared definitions for the load memory, its frame loader and the dump transmitter.
package mem_pkg;
  localparam int         MEM_DEPTH         = 256;
  localparam logic [7:0] HDR_BYTE_DEFAULT  = 8'h01;
  localparam int         MAX_COUNT_DEFAULT = 19;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CNT,
    S_ADDR,
    S_DATA,
    S_CSUM
  } dump_state_t;
endpackage

// File: rtl/byte_fifo2.sv
// Two-entry byte FIFO. Simultaneous push and pop are accepted even when full.
module byte_fifo2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  byte_t      wdata,
  input  logic       pop,
  output byte_t      rdata,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  byte_t      mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so nothing undefined reaches the link.
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/mem_dump_tx.sv
// Reads a block of the load memory and sends it as a loader-compatible byte frame:
// header, count, addr, data..., checksum. Link handshake: a byte moves when out_valid && out_ready.
module mem_dump_tx
  import mem_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEFAULT,
  parameter int         MAX_COUNT = MAX_COUNT_DEFAULT,
  parameter int         AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    start_count,
  input  logic [AW-1:0] start_addr,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic [7:0]    out_byte,
  output logic          out_valid,
  input  logic          out_ready,
  output dump_state_t   state_dbg
);

  localparam int             EW    = AW + 9;
  localparam logic [EW-1:0]  DEPTH = EW'(1) << AW;

  dump_state_t   state_q, state_d;
  logic [7:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    rd_issued_q;
  logic [7:0]    sent_q;
  logic [7:0]    csum_q;
  logic          rd_pend_q;
  logic          done_q;
  logic          error_q;

  logic [EW-1:0] end_sum;
  logic          start_ok;
  logic          accept;
  logic          xfer;
  logic          pop;
  logic          fetch_phase;
  logic [1:0]    committed;

  byte_t         fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_count;

  assign end_sum  = EW'(start_addr) + EW'(start_count);
  assign start_ok = (start_count <= 8'(MAX_COUNT)) && (end_sum <= DEPTH);
  assign accept   = (state_q == S_IDLE) && start && start_ok;

  assign xfer        = out_valid && out_ready;
  assign pop         = (state_q == S_DATA) && xfer;
  assign fetch_phase = (state_q == S_CNT) || (state_q == S_ADDR) || (state_q == S_DATA);
  // Occupancy after this cycle's pop plus the read still in flight; keeping it below 2
  // before issuing bounds the FIFO at 2 entries while still sustaining one read per cycle.
  assign committed   = fifo_count - {1'b0, pop} + {1'b0, rd_pend_q};
  assign mem_rd_en   = fetch_phase && (rd_issued_q < cnt_q) && (committed < 2'd2)
                       && !(fifo_full && !pop);
  assign mem_addr    = mem_rd_en ? (addr_q + AW'(rd_issued_q)) : '0;

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign state_dbg = state_q;

  byte_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_pend_q),
    .wdata (mem_rd_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    case (state_q)
      S_IDLE: if (accept) state_d = S_HDR;
      S_HDR: begin
        out_valid = 1'b1;
        out_byte  = HDR_BYTE;
        if (xfer) state_d = S_CNT;
      end
      S_CNT: begin
        out_valid = 1'b1;
        out_byte  = cnt_q;
        if (xfer) state_d = S_ADDR;
      end
      S_ADDR: begin
        out_valid = 1'b1;
        out_byte  = 8'(addr_q);
        if (xfer) state_d = (cnt_q == 8'd0) ? S_CSUM : S_DATA;
      end
      S_DATA: begin
        out_valid = !fifo_empty;
        out_byte  = fifo_rdata;
        if (xfer && (sent_q == cnt_q - 8'd1)) state_d = S_CSUM;
      end
      S_CSUM: begin
        out_valid = 1'b1;
        out_byte  = 8'h00 - csum_q;
        if (xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'h00;
      addr_q      <= '0;
      rd_issued_q <= 8'h00;
      sent_q      <= 8'h00;
      csum_q      <= 8'h00;
      rd_pend_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= mem_rd_en;
      done_q    <= (state_q == S_CSUM) && xfer;
      error_q   <= (state_q == S_IDLE) && start && !start_ok;
      if (accept) begin
        cnt_q       <= start_count;
        addr_q      <= start_addr;
        rd_issued_q <= 8'h00;
        sent_q      <= 8'h00;
        csum_q      <= 8'h00;
      end else begin
        if (mem_rd_en) rd_issued_q <= rd_issued_q + 8'd1;
        if (xfer) begin
          case (state_q)
            S_CNT:   csum_q <= csum_q + cnt_q;
            S_ADDR:  csum_q <= csum_q + 8'(addr_q);
            S_DATA: begin
              csum_q <= csum_q + out_byte;
              sent_q <= sent_q + 8'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed and randomized frames for mem_dump_tx against a byte-list reference model and a loader model.
module tb_mem_dump_tx;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  start_count;
  logic [7:0]  start_addr;
  logic        busy;
  logic        done;
  logic        error;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  dump_state_t state_dbg;

  mem_dump_tx dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_count (start_count),
    .start_addr  (start_addr),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] tb_mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  int         rd_count, done_count, err_count, valid_count, first_v, last_v, cyc;
  logic [7:0] exp_rd_addr;
  bit         rand_ready = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_byte;

  // memory read port: data valid one cycle after the strobe
  initial mem_rd_data = 8'h00;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= tb_mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sink readiness
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // link / memory monitor
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_byte", {24'b0, out_byte}, {24'b0, stall_byte});
      end
      stall_prev = out_valid && !out_ready;
      stall_byte = out_byte;
      if (out_valid) begin
        if (valid_count == 0) first_v = cyc;
        last_v = cyc;
        valid_count++;
      end
      if (out_valid && out_ready) rx_q.push_back(out_byte);
      if (mem_rd_en) begin
        check("rd_addr", {24'b0, mem_addr}, {24'b0, exp_rd_addr});
        exp_rd_addr++;
        rd_count++;
      end
      if (done)  done_count++;
      if (error) err_count++;
    end
  end

  task automatic clear_mon();
    rx_q.delete();
    rd_count = 0; done_count = 0; err_count = 0; valid_count = 0;
    first_v = 0; last_v = 0;
  endtask

  // reference frame: header, count, addr, data, then the byte that makes the sum zero
  task automatic build_exp(input int cnt, input int addr);
    int sum;
    exp_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'(cnt));
    exp_q.push_back(8'(addr));
    sum = cnt + addr;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(tb_mem[addr + i]);
      sum += int'(tb_mem[addr + i]);
    end
    exp_q.push_back(8'((256 - (sum % 256)) % 256));
  endtask

  task automatic launch(input int cnt, input int addr, input bit rnd, input string tag);
    clear_mon();
    exp_rd_addr = 8'(addr);
    build_exp(cnt, addr);
    @(posedge clk); #1;
    rand_ready  = rnd;
    start       = 1'b1;
    start_count = 8'(cnt);
    start_addr  = 8'(addr);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_first_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic finish(input int cnt, input bit rnd, input string tag);
    int n = 0;
    while (done_count == 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, {31'b0, (done_count != 0)}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rand_ready = 1'b0;
    check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    check({tag, "_done_cnt"}, done_count, 32'd1);
    check({tag, "_reads"}, rd_count, cnt);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    if (!rnd) begin
      check({tag, "_valid_cycles"}, valid_count, cnt + 4);
      check({tag, "_no_bubbles"}, last_v - first_v + 1, cnt + 4);
    end
  endtask

  task automatic reject(input int cnt, input int addr, input string tag);
    clear_mon();
    @(posedge clk); #1;
    start       = 1'b1;
    start_count = 8'(cnt);
    start_addr  = 8'(addr);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_error"}, {31'b0, error}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_err_pulses"}, err_count, 32'd1);
    check({tag, "_no_reads"}, rd_count, 32'd0);
    check({tag, "_no_valid"}, valid_count, 32'd0);
    check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  {31'b0, busy},      32'd0);
    check({tag, "_done"},  {31'b0, done},      32'd0);
    check({tag, "_error"}, {31'b0, error},     32'd0);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_rd_en"}, {31'b0, mem_rd_en}, 32'd0);
    check({tag, "_addr"},  {24'b0, mem_addr},  32'd0);
    check({tag, "_byte"},  {24'b0, out_byte},  32'd0);
    check({tag, "_state"}, 32'(state_dbg),     32'(S_IDLE));
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL global_timeout: observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, addr, n, mism;
    bit loader_err;
    logic [7:0] shadow [256];
    int sum;

    for (int i = 0; i < 256; i++) tb_mem[i] = 8'($urandom_range(0, 255));
    tb_mem[8'h10] = 8'hAA; tb_mem[8'h11] = 8'hBB; tb_mem[8'h12] = 8'hCC;
    tb_mem[8'hFF] = 8'h5A;
    reset = 1'b1; start = 1'b0; start_count = 8'h00; start_addr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;

    launch(3, 8'h10, 1'b0, "basic");  finish(3, 1'b0, "basic");
    launch(0, 8'h20, 1'b0, "zero");   finish(0, 1'b0, "zero");
    reject(20, 8'h00, "bad_count");
    reject(2, 8'hFF, "range_over");
    launch(1, 8'hFF, 1'b0, "range_last"); finish(1, 1'b0, "range_last");
    launch(19, 8'hED, 1'b0, "range_full"); finish(19, 1'b0, "range_full");
    reject(19, 8'hEE, "range_over19");

    // backpressure with loader loopback
    for (int k = 0; k < 3; k++) begin
      cnt  = (k == 0) ? 19 : $urandom_range(1, 19);
      addr = $urandom_range(0, 256 - cnt);
      for (int i = 0; i < cnt; i++) tb_mem[addr + i] = 8'($urandom_range(0, 255));
      launch(cnt, addr, 1'b1, $sformatf("bp%0d", k));
      finish(cnt, 1'b1, $sformatf("bp%0d", k));
      for (int i = 0; i < 256; i++) shadow[i] = tb_mem[i];
      loader_err = (rx_q.size() < 4) || (rx_q[0] != 8'h01) || (rx_q.size() != int'(rx_q[1]) + 4);
      if (!loader_err) begin
        sum = 0;
        for (int i = 1; i < rx_q.size(); i++) sum += int'(rx_q[i]);
        if (sum % 256 != 0) loader_err = 1'b1;
        for (int i = 0; i < int'(rx_q[1]); i++) shadow[(int'(rx_q[2]) + i) % 256] = rx_q[3 + i];
      end
      mism = 0;
      for (int i = 0; i < 256; i++) if (shadow[i] !== tb_mem[i]) mism++;
      check($sformatf("bp%0d_loader_err", k), {31'b0, loader_err}, 32'd0);
      check($sformatf("bp%0d_loader_mem", k), mism, 32'd0);
    end

    // start while busy must be ignored
    launch(3, 8'h40, 1'b0, "busy_start");
    start = 1'b1; start_count = 8'd30; start_addr = 8'h00;
    @(posedge clk); #1;
    start = 1'b1; start_count = 8'd1; start_addr = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    finish(3, 1'b0, "busy_start");
    check("busy_start_no_error", err_count, 32'd0);

    // reset while DATA byte 2 is on the link
    launch(5, 8'h60, 1'b0, "midreset");
    n = 0;
    while (rx_q.size() < 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("midreset_reached", {31'b0, (rx_q.size() == 5)}, 32'd1);
    check("midreset_in_data", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_quiet("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    launch(1, 8'h70, 1'b0, "post_reset"); finish(1, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
